// File: rtl/encoder8_3_seq.sv
// ============================================================================
//  Module      : encoder8_3_seq
//  Description : Sequential 8-to-3 encoder. Accepts a multi-hot vector via a
//                valid/ready handshake and emits the binary index of every
//                set bit, lowest index first, one index per output handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module encoder8_3_seq (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] a,
   input  logic       a_valid,
   output logic       a_ready,
   output logic [2:0] y,
   output logic       y_valid,
   input  logic       y_ready,
   output logic       y_last,
   output logic       zero
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] p_q, p_d;
   logic       zero_q, zero_d;

   logic [2:0] low_idx;
   logic       single_bit;

   // Lowest set bit of the pending register; bit 0 has the highest priority.
   always_comb begin
      low_idx = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (p_q[i]) begin
            low_idx = 3'(i);
         end
      end
   end

   // Exactly one pending bit: clearing the lowest set bit leaves nothing.
   assign single_bit = (p_q != 8'd0) && ((p_q & (p_q - 8'd1)) == 8'd0);

   // Outputs depend on state and pending bits only; y is forced to 0 when idle.
   always_comb begin
      a_ready = (state_q == IDLE);
      y_valid = (state_q == EMIT);
      y       = (state_q == EMIT) ? low_idx : 3'd0;
      y_last  = (state_q == EMIT) && single_bit;
      zero    = zero_q;
   end

   // Next-state logic: capture a vector in IDLE, retire one bit per handshake in EMIT.
   always_comb begin
      state_d = state_q;
      p_d     = p_q;
      zero_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (a_valid) begin
               if (a != 8'd0) begin
                  p_d     = a;
                  state_d = EMIT;
               end else begin
                  zero_d  = 1'b1;
               end
            end
         end
         EMIT: begin
            if (y_ready) begin
               // Clearing the lowest set bit retires the index currently on y.
               p_d = p_q & (p_q - 8'd1);
               if (single_bit) begin
                  p_d     = 8'd0;
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
            p_d     = 8'd0;
         end
      endcase
   end

   // State, pending-bit and zero-pulse registers with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         p_q     <= 8'd0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         p_q     <= p_d;
         zero_q  <= zero_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_encoder8_3_seq.sv
// ============================================================================
//  Module      : tb_encoder8_3_seq
//  Description : Directed self-checking bench for encoder8_3_seq.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_encoder8_3_seq;

   logic       clk;
   logic       rst_n;
   logic [7:0] a;
   logic       a_valid;
   logic       a_ready;
   logic [2:0] y;
   logic       y_valid;
   logic       y_ready;
   logic       y_last;
   logic       zero;

   int total = 0;
   int bad   = 0;

   encoder8_3_seq dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .a       (a),
      .a_valid (a_valid),
      .a_ready (a_ready),
      .y       (y),
      .y_valid (y_valid),
      .y_ready (y_ready),
      .y_last  (y_last),
      .zero    (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One comparison: counts it, and counts/reports a mismatch.
   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      int e;
      logic [7:0] pat;
      logic [2:0] seq4 [4];

      // Reset held with a valid all-ones vector on the input.
      rst_n   = 1'b0;
      a       = 8'hFF;
      a_valid = 1'b1;
      y_ready = 1'b1;
      #3;
      chk("rst_a_ready", {7'd0, a_ready}, 8'd1);
      chk("rst_y_valid", {7'd0, y_valid}, 8'd0);
      chk("rst_zero",    {7'd0, zero},    8'd0);
      chk("rst_y",       {5'd0, y},       8'd0);
      chk("rst_y_last",  {7'd0, y_last},  8'd0);
      tick();
      tick();
      chk("rst_hold_a_ready", {7'd0, a_ready}, 8'd1);
      chk("rst_hold_y_valid", {7'd0, y_valid}, 8'd0);
      rst_n = 1'b1;

      // First edge after release accepts 8'hFF: beats 0..7, y_last on 7.
      tick();
      a_valid = 1'b0;
      for (int k = 0; k < 8; k++) begin
         chk("ff_y_valid", {7'd0, y_valid}, 8'd1);
         chk("ff_y",       {5'd0, y},       8'(k));
         chk("ff_y_last",  {7'd0, y_last},  (k == 7) ? 8'd1 : 8'd0);
         chk("ff_a_ready", {7'd0, a_ready}, 8'd0);
         tick();
      end
      chk("ff_done_a_ready", {7'd0, a_ready}, 8'd1);
      chk("ff_done_y_valid", {7'd0, y_valid}, 8'd0);

      // One-hot vectors: full inverse of the 3-to-8 decoder.
      for (int i = 0; i < 8; i++) begin
         a       = 8'd1 << i;
         a_valid = 1'b1;
         tick();
         a_valid = 1'b0;
         chk("oh_y_valid", {7'd0, y_valid}, 8'd1);
         chk("oh_y",       {5'd0, y},       8'(i));
         chk("oh_y_last",  {7'd0, y_last},  8'd1);
         tick();
         chk("oh_a_ready", {7'd0, a_ready}, 8'd1);
         chk("oh_y_valid_after", {7'd0, y_valid}, 8'd0);
      end

      // 8'b1010_0110 gives 1,2,5,7; input changed after accept must be ignored.
      seq4[0] = 3'd1; seq4[1] = 3'd2; seq4[2] = 3'd5; seq4[3] = 3'd7;
      a       = 8'b1010_0110;
      a_valid = 1'b1;
      tick();
      a_valid = 1'b0;
      a       = 8'hFF;
      for (int k = 0; k < 4; k++) begin
         chk("mh_y_valid", {7'd0, y_valid}, 8'd1);
         chk("mh_y",       {5'd0, y},       {5'd0, seq4[k]});
         chk("mh_y_last",  {7'd0, y_last},  (k == 3) ? 8'd1 : 8'd0);
         tick();
      end
      chk("mh_done_a_ready", {7'd0, a_ready}, 8'd1);

      // 8'hFF with y_ready pattern 1,0,0 repeating: stalls hold y.
      a       = 8'hFF;
      a_valid = 1'b1;
      tick();
      a_valid = 1'b0;
      e = 0;
      for (int c = 0; c < 40 && e < 8; c++) begin
         y_ready = (c % 3 == 0);
         #1;
         chk("st_y_valid", {7'd0, y_valid}, 8'd1);
         chk("st_y",       {5'd0, y},       8'(e));
         chk("st_y_last",  {7'd0, y_last},  (e == 7) ? 8'd1 : 8'd0);
         chk("st_a_ready", {7'd0, a_ready}, 8'd0);
         tick();
         if (y_ready) e++;
      end
      chk("st_beat_count", 8'(e), 8'd8);
      chk("st_done_a_ready", {7'd0, a_ready}, 8'd1);
      chk("st_done_y_valid", {7'd0, y_valid}, 8'd0);
      y_ready = 1'b1;

      // Two back-to-back zero vectors: two consecutive zero pulses.
      a       = 8'h00;
      a_valid = 1'b1;
      tick();
      chk("z1_zero",    {7'd0, zero},    8'd1);
      chk("z1_y_valid", {7'd0, y_valid}, 8'd0);
      chk("z1_a_ready", {7'd0, a_ready}, 8'd1);
      tick();
      a_valid = 1'b0;
      chk("z2_zero",    {7'd0, zero},    8'd1);
      chk("z2_y_valid", {7'd0, y_valid}, 8'd0);
      tick();
      chk("z3_zero",    {7'd0, zero},    8'd0);
      chk("z3_y_valid", {7'd0, y_valid}, 8'd0);

      // 8'hC3 interrupted by reset after the y=1 beat.
      pat     = 8'hC3;
      a       = pat;
      a_valid = 1'b1;
      tick();
      a_valid = 1'b0;
      chk("c3_y0", {5'd0, y}, 8'd0);
      tick();
      chk("c3_y1", {5'd0, y}, 8'd1);
      tick();
      chk("c3_y6", {5'd0, y}, 8'd6);
      rst_n = 1'b0;
      #1;
      chk("c3_rst_y_valid", {7'd0, y_valid}, 8'd0);
      chk("c3_rst_a_ready", {7'd0, a_ready}, 8'd1);
      chk("c3_rst_y",       {5'd0, y},       8'd0);
      tick();
      rst_n   = 1'b1;
      a       = 8'h10;
      a_valid = 1'b1;
      tick();
      a_valid = 1'b0;
      chk("post_y_valid", {7'd0, y_valid}, 8'd1);
      chk("post_y",       {5'd0, y},       8'd4);
      chk("post_y_last",  {7'd0, y_last},  8'd1);
      tick();
      chk("post_a_ready", {7'd0, a_ready}, 8'd1);
      chk("post_y_valid_after", {7'd0, y_valid}, 8'd0);
      tick();
      chk("post_no_more_beats", {7'd0, y_valid}, 8'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
